// File: rtl/kernel_bc_pkg.sv
// Shared definitions for the BC kernel frontier path: ID markers, word field
// helpers and the unpacker FSM states. The upstream packer imports this too.
package kernel_bc_pkg;

    localparam int ID_WIDTH   = 32;
    localparam int DATA_WIDTH = 2 * ID_WIDTH;
    localparam int CNT_WIDTH  = 32;

    localparam logic [ID_WIDTH-1:0] INVALID_ID = 32'hFFFF_FFFF;
    localparam logic [ID_WIDTH-1:0] END_ID     = 32'hFFFF_FFFE;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_LO    = 2'd1,
        S_HI    = 2'd2
    } frontier_state_t;

    // A frontier word packs two IDs as {hi, lo}; lo is always emitted first.
    function automatic logic [ID_WIDTH-1:0] word_lo(input logic [DATA_WIDTH-1:0] w);
        return w[ID_WIDTH-1:0];
    endfunction

    function automatic logic [ID_WIDTH-1:0] word_hi(input logic [DATA_WIDTH-1:0] w);
        return w[DATA_WIDTH-1:ID_WIDTH];
    endfunction

endpackage

// File: rtl/kernel_bc_frontier_unpack_if.sv
// Frontier unpacker bus: 64-bit FWFT FIFO read side, 32-bit FIFO write side
// and the per-level completion report.
interface kernel_bc_frontier_unpack_if
    import kernel_bc_pkg::*;
;
    logic                  in_empty_n;
    logic [DATA_WIDTH-1:0] in_dout;
    logic                  in_read;
    logic                  out_full_n;
    logic                  out_write;
    logic [ID_WIDTH-1:0]   out_din;
    logic                  level_done;
    logic [CNT_WIDTH-1:0]  level_cnt;

    modport master (
        input  in_empty_n, in_dout, out_full_n,
        output in_read, out_write, out_din, level_done, level_cnt
    );

    modport slave (
        output in_empty_n, in_dout, out_full_n,
        input  in_read, out_write, out_din, level_done, level_cnt
    );

endinterface

// File: rtl/kernel_bc_frontier_unpack.sv
// Unpacks {hi,lo} frontier words into single IDs, drops INVALID_ID padding and
// reports the number of IDs emitted per BFS level when an END_ID word arrives.
module kernel_bc_frontier_unpack
    import kernel_bc_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    kernel_bc_frontier_unpack_if.master   bus
);

    frontier_state_t       state;
    logic [DATA_WIDTH-1:0] word_r;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  cnt_next;
    logic                  level_done_r;
    logic [CNT_WIDTH-1:0]  level_cnt_r;

    logic [ID_WIDTH-1:0]   lo;
    logic [ID_WIDTH-1:0]   hi;
    logic                  lo_valid;
    logic                  hi_valid;
    logic                  hi_done;
    logic                  pop_is_end;
    logic                  in_read;
    logic                  out_write;
    logic [ID_WIDTH-1:0]   out_din;

    assign lo         = word_lo(word_r);
    assign hi         = word_hi(word_r);
    assign lo_valid   = (lo != INVALID_ID);
    assign hi_valid   = (hi != INVALID_ID);
    assign pop_is_end = (word_lo(bus.in_dout) == END_ID);

    // Popping the next word while the hi half goes out keeps one ID per cycle;
    // this is the only place out_full_n reaches in_read.
    always_comb begin
        in_read   = 1'b0;
        out_write = 1'b0;
        out_din   = lo;
        hi_done   = 1'b0;
        case (state)
            S_FETCH: begin
                in_read = bus.in_empty_n;
            end
            S_LO: begin
                out_write = lo_valid & bus.out_full_n;
            end
            S_HI: begin
                out_din   = hi;
                out_write = hi_valid & bus.out_full_n;
                hi_done   = ~hi_valid | bus.out_full_n;
                in_read   = hi_done & bus.in_empty_n;
            end
            default: begin
                in_read = 1'b0;
            end
        endcase
        if (reset) begin
            in_read   = 1'b0;
            out_write = 1'b0;
        end
    end

    assign cnt_next = (out_write && (cnt != '1)) ? cnt + 1'b1 : cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_FETCH;
            word_r       <= '0;
            cnt          <= '0;
            level_done_r <= 1'b0;
            level_cnt_r  <= '0;
        end else begin
            level_done_r <= 1'b0;
            cnt          <= cnt_next;
            if (in_read) begin
                // A terminator's count includes a hi half written this same cycle.
                if (pop_is_end) begin
                    level_done_r <= 1'b1;
                    level_cnt_r  <= cnt_next;
                    cnt          <= '0;
                    state        <= S_FETCH;
                end else begin
                    word_r <= bus.in_dout;
                    state  <= S_LO;
                end
            end else begin
                case (state)
                    S_FETCH: state <= S_FETCH;
                    S_LO: begin
                        if (!lo_valid || out_write) begin
                            state <= S_HI;
                        end
                    end
                    S_HI: begin
                        if (hi_done) begin
                            state <= S_FETCH;
                        end
                    end
                    default: state <= S_FETCH;
                endcase
            end
        end
    end

    assign bus.in_read    = in_read;
    assign bus.out_write  = out_write;
    assign bus.out_din    = out_din;
    assign bus.level_done = level_done_r;
    assign bus.level_cnt  = level_cnt_r;

endmodule

// File: tb/tb_kernel_bc_frontier_unpack.sv
// Scoreboard bench for the frontier unpacker: a FIFO source, a word-level
// reference model feeding expected queues, and a monitor that checks writes.
module tb_kernel_bc_frontier_unpack;
    import kernel_bc_pkg::*;

    logic clk;
    logic reset;

    kernel_bc_frontier_unpack_if bus ();

    kernel_bc_frontier_unpack dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_WIDTH-1:0] src_q[$];
    logic [ID_WIDTH-1:0]   exp_id_q[$];
    logic [CNT_WIDTH-1:0]  exp_lvl_q[$];
    int unsigned           model_cnt;
    int                    checks;
    int                    passes;
    int                    full_mode;
    bit                    mon_en;
    bit                    pop_pending;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model works on whole words: padding dropped, terminator closes a level.
    task automatic applyStimulus(input logic [DATA_WIDTH-1:0] w);
        logic [ID_WIDTH-1:0] l;
        logic [ID_WIDTH-1:0] h;
        l = w[31:0];
        h = w[63:32];
        src_q.push_back(w);
        if (l == END_ID) begin
            exp_lvl_q.push_back(CNT_WIDTH'(model_cnt));
            model_cnt = 0;
        end else begin
            if (l != INVALID_ID) begin
                exp_id_q.push_back(l);
                model_cnt++;
            end
            if (h != INVALID_ID) begin
                exp_id_q.push_back(h);
                model_cnt++;
            end
        end
    endtask

    function automatic logic [ID_WIDTH-1:0] randHalf();
        if ($urandom_range(0, 4) == 0) return INVALID_ID;
        return ID_WIDTH'($urandom_range(0, 4095));
    endfunction

    function automatic logic [DATA_WIDTH-1:0] randWord();
        if ($urandom_range(0, 9) == 0) return {ID_WIDTH'($urandom), END_ID};
        return {randHalf(), randHalf()};
    endfunction

    // Upstream FIFO and downstream space, updated away from the active edge.
    initial begin
        bus.in_empty_n = 1'b0;
        bus.in_dout    = '0;
        bus.out_full_n = 1'b1;
        forever begin
            @(negedge clk);
            if (pop_pending && src_q.size() > 0) void'(src_q.pop_front());
            bus.in_empty_n = (src_q.size() > 0);
            bus.in_dout    = (src_q.size() > 0) ? src_q[0] : '0;
            case (full_mode)
                1:       bus.out_full_n = 1'b0;
                2:       bus.out_full_n = 1'b1;
                default: bus.out_full_n = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: compares every write and level report against the scoreboard.
    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            if (bus.in_read) checkOutput("read_when_empty", 64'(bus.in_empty_n), 64'd1);
            if (bus.out_write) begin
                checkOutput("write_when_full", 64'(bus.out_full_n), 64'd1);
                if (exp_id_q.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_write: actual=%0h expected=no write at %0t", bus.out_din, $time);
                end else begin
                    checkOutput("out_din", 64'(bus.out_din), 64'(exp_id_q.pop_front()));
                end
            end
            if (bus.level_done) begin
                if (exp_lvl_q.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_level_done: actual=%0h expected=no pulse at %0t", bus.level_cnt, $time);
                end else begin
                    checkOutput("level_cnt", 64'(bus.level_cnt), 64'(exp_lvl_q.pop_front()));
                end
            end
            pop_pending = bus.in_read;
        end else begin
            pop_pending = 1'b0;
        end
    end

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while ((src_q.size() != 0 || exp_id_q.size() != 0 || exp_lvl_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checkOutput("drain_timeout", 64'(n < budget), 64'd1);
    endtask

    initial begin
        int first;
        int last;
        int nwr;
        checks      = 0;
        passes      = 0;
        model_cnt   = 0;
        full_mode   = 2;
        mon_en      = 1'b0;
        pop_pending = 1'b0;
        reset       = 1'b1;
        repeat (3) @(posedge clk);

        // Word waiting while reset is high must not be popped.
        applyStimulus(64'h0000_0002_0000_0001);
        @(negedge clk);
        #3;
        checkOutput("reset_in_read", 64'(bus.in_read), 64'd0);
        checkOutput("reset_out_write", 64'(bus.out_write), 64'd0);
        checkOutput("reset_level_done", 64'(bus.level_done), 64'd0);
        checkOutput("reset_level_cnt", 64'(bus.level_cnt), 64'd0);
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;
        waitIdle(100);

        // Three full words with no stall should give six IDs back to back.
        applyStimulus(64'h0000_0002_0000_0001);
        applyStimulus(64'h0000_0004_0000_0003);
        applyStimulus(64'h0000_0006_0000_0005);
        first = -1;
        last  = -1;
        nwr   = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #3;
            if (bus.out_write) begin
                if (first < 0) first = i;
                last = i;
                nwr++;
            end
        end
        checkOutput("burst_writes", 64'(nwr), 64'd6);
        checkOutput("burst_span", 64'(last - first), 64'd5);
        waitIdle(100);

        // Padding, a terminator, back-to-back terminators (second is an empty level).
        applyStimulus({32'd5, INVALID_ID});
        applyStimulus({INVALID_ID, 32'd7});
        applyStimulus(64'h0000_0002_0000_0001);
        applyStimulus({32'd3, INVALID_ID});
        applyStimulus({32'h1234_5678, END_ID});
        applyStimulus({INVALID_ID, INVALID_ID});
        applyStimulus({32'd0, END_ID});
        applyStimulus({32'd0, END_ID});
        waitIdle(200);

        // Backpressure while lo=9 is held.
        full_mode = 1;
        applyStimulus(64'h0000_000A_0000_0009);
        applyStimulus(64'h0000_000C_0000_000B);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #3;
            checkOutput("stall_out_write", 64'(bus.out_write), 64'd0);
            checkOutput("stall_out_din", 64'(bus.out_din), 64'd9);
            checkOutput("stall_in_read", 64'(bus.in_read), 64'd0);
        end
        full_mode = 2;
        @(negedge clk);
        #3;
        checkOutput("stall_release_write", 64'(bus.out_write), 64'd1);
        waitIdle(100);

        // Reset while the hi half is held: the held ID must never appear.
        full_mode = 1;
        src_q.push_back({32'h55, INVALID_ID});
        repeat (5) @(negedge clk);
        #3;
        checkOutput("held_hi_din", 64'(bus.out_din), 64'h55);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        model_cnt = 0;
        full_mode = 2;
        #3;
        checkOutput("midreset_level_done", 64'(bus.level_done), 64'd0);
        checkOutput("midreset_level_cnt", 64'(bus.level_cnt), 64'd0);
        applyStimulus(64'h0000_0077_0000_0066);
        waitIdle(100);

        // Randomized stream with random backpressure.
        full_mode = 0;
        for (int i = 0; i < 300; i++) applyStimulus(randWord());
        applyStimulus({32'd0, END_ID});
        waitIdle(5000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
